// File: rtl/hilo_muldiv_issue.sv
// hilo_muldiv_issue: owns HI/LO, runs a fixed-latency multiplier and drives an external multicycle divider
module hilo_muldiv_issue #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_valid,
    output logic        div_sig,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [63:0] div_c
);
    typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DIV_CAPTURE} state_t;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] opa, opb;
    logic sig, discard, accept, is_mul, is_div, mul_done, write_ok;
    logic [63:0] ext_a, ext_b, product;
    assign accept    = state == IDLE && req_valid && !flush;
    assign is_mul    = req_op == 3'd1 || req_op == 3'd2;
    assign is_div    = req_op == 3'd3 || req_op == 3'd4;
    assign mul_done  = state == MUL_WAIT && cnt == '0;
    assign write_ok  = !discard && !flush;
    assign busy      = state != IDLE;
    assign div_sig   = sig;
    assign div_a     = opa;
    assign div_b     = opb;
    assign ext_a     = sig ? {{32{opa[31]}}, opa} : {32'b0, opa};
    assign ext_b     = sig ? {{32{opb[31]}}, opb} : {32'b0, opb};
    assign product   = ext_a * ext_b;
    // next-state and the one-cycle divider start pulse
    always_comb begin
        state_nx  = state;
        div_valid = 1'b0;
        case (state)
            IDLE:        state_nx = (accept && is_mul) ? MUL_WAIT : (accept && is_div) ? DIV_ISSUE : IDLE;
            MUL_WAIT:    state_nx = (cnt == '0) ? IDLE : MUL_WAIT;
            DIV_ISSUE: begin
                div_valid = 1'b1;
                state_nx  = DIV_WAIT;
            end
            DIV_WAIT:    state_nx = div_done ? DIV_CAPTURE : DIV_WAIT;
            DIV_CAPTURE: state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end
    // operands, latency counter, squash flag and the HI/LO pair
    always_ff @(posedge clk) begin
        if (!resetn) begin
            opa     <= '0;
            opb     <= '0;
            sig     <= 1'b0;
            cnt     <= '0;
            discard <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept && (is_mul || is_div)) begin
                opa <= req_a;
                opb <= req_b;
                sig <= req_op == 3'd1 || req_op == 3'd3;
            end
            if (accept && is_mul) cnt <= CW'(MUL_LAT - 1);
            else if (state == MUL_WAIT && cnt != '0) cnt <= cnt - 1'b1;
            discard <= (state_nx == IDLE) ? 1'b0 : (busy && flush) ? 1'b1 : discard;
            if (accept && req_op == 3'd5) hi <= req_a;
            if (accept && req_op == 3'd6) lo <= req_a;
            if (mul_done && write_ok) {hi, lo} <= product;
            if (state == DIV_CAPTURE && write_ok) {hi, lo} <= div_c;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_issue.sv
// tb_hilo_muldiv_issue: vector table plus corner sequences against a 32-cycle divider model
module tb_hilo_muldiv_issue;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          busy;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
        int          busy, pulses;
    } exp_t;

    logic clk = 0, resetn = 0, req_valid = 0, flush = 0;
    logic [2:0] req_op = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic busy, div_valid, div_sig, div_done;
    logic [31:0] hi, lo, div_a, div_b;
    logic [63:0] div_c;
    int total = 0, bad = 0, pulses = 0, unstable = 0;
    logic in_div = 0, ls = 0;
    logic [31:0] la = 0, lb = 0;
    logic running = 0;
    int dcnt = 0;
    vec_t vt[13];
    exp_t exp_q[$];

    hilo_muldiv_issue #(.MUL_LAT(3)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy), .hi(hi), .lo(lo),
        .div_valid(div_valid), .div_sig(div_sig), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] divm(input logic [31:0] a, input logic [31:0] b, input logic s);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (s) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    // divider model: done in the 32nd cycle after the start pulse
    always @(posedge clk) begin
        if (!resetn) running <= 0;
        else if (div_valid) begin
            running <= 1;
            dcnt    <= 0;
            div_c   <= divm(div_a, div_b, div_sig);
        end else if (running) begin
            if (dcnt == 31) running <= 0;
            else dcnt <= dcnt + 1;
        end
    end
    assign div_done = !running || dcnt == 31;

    // count start pulses and watch divider operands for stability while a divide is live
    always @(negedge clk) begin
        if (div_valid) begin
            pulses++;
            in_div = 1;
            la = div_a;
            lb = div_b;
            ls = div_sig;
        end else if (!busy) in_div = 0;
        else if (in_div && (div_a !== la || div_b !== lb || div_sig !== ls)) unstable++;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ebusy);
        exp_t e;
        int n;
        e.hi = ehi;
        e.lo = elo;
        e.busy = ebusy;
        e.pulses = (op == 3 || op == 4) ? 1 : 0;
        exp_q.push_back(e);
        pulses = 0;
        unstable = 0;
        @(negedge clk);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 0; req_op = 0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        chk("busy_cycles", n, e.busy);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_pulses", pulses, e.pulses);
        chk("div_stable", unstable, 0);
        if (e.pulses == 1) begin
            chk("div_a", la, a);
            chk("div_b", lb, b);
            chk("div_sig", ls, op == 3);
        end
    endtask

    initial begin
        int n;
        vt[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 3};
        vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 3};
        vt[2]  = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        34};
        vt[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vt[4]  = '{3'd6, 32'h0000ABCD, 32'd0,        32'hFFFFFFFF, 32'h0000ABCD, 0};
        vt[5]  = '{3'd5, 32'h00001234, 32'd0,        32'h00001234, 32'h0000ABCD, 0};
        vt[6]  = '{3'd0, 32'd5,        32'd6,        32'h00001234, 32'h0000ABCD, 0};
        vt[7]  = '{3'd7, 32'd9,        32'd9,        32'h00001234, 32'h0000ABCD, 0};
        vt[8]  = '{3'd1, 32'd3,        32'd4,        32'd0,        32'd12,       3};
        vt[9]  = '{3'd4, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 34};
        vt[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};
        vt[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        vt[12] = '{3'd3, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 34};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_div_valid", div_valid, 0);
        chk("rst_div_sig", div_sig, 0);
        chk("rst_div_ab", {div_a, div_b}, 0);
        resetn = 1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].busy);

        // MTHI held during a divide is taken only once the unit is idle
        @(negedge clk);
        req_valid = 1; req_op = 4; req_a = 7; req_b = 2;
        @(negedge clk);
        req_op = 5; req_a = 32'h55; req_b = 0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("held_busy", n, 34);
        chk("held_hi_before", hi, 1);
        chk("held_lo_before", lo, 3);
        @(negedge clk);
        req_valid = 0; req_op = 0;
        chk("held_hi_after", hi, 32'h55);
        chk("held_lo_after", lo, 3);
        chk("held_busy_after", busy, 0);

        // flush mid-wait squashes the divide result but not its length
        @(negedge clk);
        req_valid = 1; req_op = 3; req_a = 100; req_b = 7;
        @(negedge clk);
        req_valid = 0; req_op = 0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            flush = (n == 10);
            @(negedge clk);
        end
        flush = 0;
        chk("flush_busy", n, 34);
        chk("flush_hi", hi, 32'h55);
        chk("flush_lo", lo, 3);
        run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 3);

        // flush in the final multiply cycle suppresses the write
        @(negedge clk);
        req_valid = 1; req_op = 1; req_a = 5; req_b = 5;
        @(negedge clk);
        req_valid = 0; req_op = 0;
        @(negedge clk);
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_end_busy", busy, 0);
        chk("flush_end_hi", hi, 0);
        chk("flush_end_lo", lo, 12);
        run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 3);

        // flush while idle blocks acceptance
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1; flush = 1; req_op = (k == 0) ? 3'd6 : 3'd1; req_a = 32'h77; req_b = 7;
            @(negedge clk);
            req_valid = 0; flush = 0; req_op = 0;
            chk("idle_flush_busy", busy, 0);
            chk("idle_flush_lo", lo, 6);
        end

        // reset during DIV_WAIT, then a clean divide
        @(negedge clk);
        req_valid = 1; req_op = 4; req_a = 100; req_b = 3;
        @(negedge clk);
        req_valid = 0; req_op = 0;
        repeat (5) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_div_valid", div_valid, 0);
        resetn = 1;
        run_op(3'd4, 32'd9, 32'd4, 32'd1, 32'd2, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
